// File: rtl/counter_scheduler_if.sv
// Bundles the host-side run control, limit configuration, count/status readback
// and the wrap-event valid/ready port of counter_scheduler.
// master: host/consumer side (drives start/stop/cfg_*/evt_ready); slave: scheduler side.
interface counter_scheduler_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             stop;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_chan;
    logic [WIDTH-1:0] cfg_limit;
    logic [WIDTH-1:0] count0;
    logic [WIDTH-1:0] count1;
    logic             evt_valid;
    logic             evt_ready;
    logic             evt_chan;
    logic [1:0]       ovf;
    logic             busy;

    modport master (
        output start, stop, cfg_valid, cfg_chan, cfg_limit, evt_ready,
        input  cfg_ready, count0, count1, evt_valid, evt_chan, ovf, busy
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_chan, cfg_limit, evt_ready,
        output cfg_ready, count0, count1, evt_valid, evt_chan, ovf, busy
    );
endinterface

// File: rtl/counter_scheduler.sv
// Run control (IDLE/RUN/DRAIN) for two wrap counters, round-robin wrap-event arbiter.
// Latency: wrap at edge E -> pending after E -> event presented after E+1 at the earliest.
// Backpressure: one output slot + one pending bit per channel; further wraps set sticky ovf.
//
// Ports: clk, rst (sync, active high); bus (slave modport): start/stop pulses,
// cfg_valid/cfg_ready/cfg_chan/cfg_limit limit writes (IDLE only), count0/count1,
// evt_valid/evt_ready/evt_chan event port, ovf lost-event flags, busy.
module counter_scheduler #(
    parameter int WIDTH         = 4,
    parameter int DEFAULT_LIMIT = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    counter_scheduler_if.slave     bus
);
    localparam logic [WIDTH-1:0] DEF_LIMIT = WIDTH'(DEFAULT_LIMIT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count0, count1;
    logic [WIDTH-1:0] limit0, limit1;
    logic [1:0]       pend;
    logic [1:0]       ovf;
    logic             evt_valid;
    logic             evt_chan;
    logic             last_grant;

    logic             start_go;
    logic             cnt_en;
    logic [1:0]       wrap;
    logic             slot_free;
    logic             load;
    logic             winner;
    logic [1:0]       take;

    always_comb begin
        start_go  = (state == IDLE) && bus.start;
        // The stop edge itself does not advance the counters: they freeze
        // at the values visible when stop was raised.
        cnt_en    = (state == RUN) && !bus.stop;
        wrap[0]   = cnt_en && (count0 == limit0);
        wrap[1]   = cnt_en && (count1 == limit1);
        slot_free = !evt_valid || bus.evt_ready;
        load      = slot_free && (pend != 2'b00);
        // Tie goes to the channel that was not granted last; otherwise the
        // only pending channel wins.
        winner    = (pend == 2'b11) ? ~last_grant : pend[1];
        take      = load ? {winner, ~winner} : 2'b00;

        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (bus.stop) state_nxt = DRAIN;
            DRAIN:   if ((pend == 2'b00) && slot_free) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count0     <= '0;
            count1     <= '0;
            limit0     <= DEF_LIMIT;
            limit1     <= DEF_LIMIT;
            pend       <= 2'b00;
            ovf        <= 2'b00;
            evt_valid  <= 1'b0;
            evt_chan   <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;

            if (bus.cfg_valid && (state == IDLE)) begin
                if (bus.cfg_chan) limit1 <= bus.cfg_limit;
                else              limit0 <= bus.cfg_limit;
            end

            if (start_go) begin
                count0 <= '0;
                count1 <= '0;
            end else if (cnt_en) begin
                count0 <= wrap[0] ? '0 : count0 + 1'b1;
                count1 <= wrap[1] ? '0 : count1 + 1'b1;
            end

            // A wrap on the same edge its pending bit moves to the slot refills it.
            pend <= (pend & ~take) | wrap;

            if (start_go) ovf <= 2'b00;
            else          ovf <= ovf | (wrap & pend & ~take);

            if (load) begin
                evt_valid  <= 1'b1;
                evt_chan   <= winner;
                last_grant <= winner;
            end else if (bus.evt_ready) begin
                evt_valid  <= 1'b0;
            end
        end
    end

    assign bus.cfg_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.count0    = count0;
    assign bus.count1    = count1;
    assign bus.evt_valid = evt_valid;
    assign bus.evt_chan  = evt_chan;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: directed scenarios plus random run control,
// every cycle compared against a behavioural model of phases, modular counters and
// a pending-set / single-slot event queue.
module tb_counter_scheduler;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;

    counter_scheduler_if #(.WIDTH(WIDTH)) bus ();

    counter_scheduler #(.WIDTH(WIDTH), .DEFAULT_LIMIT(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_phase;         // 0 idle, 1 run, 2 drain
    int m_cnt[2];
    int m_lim[2];
    bit m_pend[2];
    bit m_vld;
    int m_chan;
    bit m_ovf[2];
    int m_last;

    task automatic check_val(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit run, free_s, ld, taken, any_pend;
        bit w[2];
        int ncnt[2];
        int win, old_phase;
        if (rst) begin
            m_phase = 0; m_cnt = '{0, 0}; m_lim = '{10, 10};
            m_pend = '{0, 0}; m_vld = 0; m_chan = 0; m_ovf = '{0, 0}; m_last = 1;
            return;
        end
        old_phase = m_phase;
        any_pend  = m_pend[0] || m_pend[1];
        run = (m_phase == 1) && !bus.stop;
        for (int c = 0; c < 2; c++) begin
            w[c]    = run && (m_cnt[c] == m_lim[c]);
            ncnt[c] = run ? (m_cnt[c] + 1) % (m_lim[c] + 1) : m_cnt[c];
        end
        free_s = !m_vld || bus.evt_ready;
        ld     = free_s && any_pend;
        win    = (m_pend[0] && m_pend[1]) ? 1 - m_last : (m_pend[0] ? 0 : 1);
        for (int c = 0; c < 2; c++) begin
            taken = ld && (win == c);
            if (w[c] && m_pend[c] && !taken) m_ovf[c] = 1;
            m_pend[c] = (m_pend[c] && !taken) || w[c];
        end
        if (ld) begin
            m_vld = 1; m_chan = win; m_last = win;
        end else if (bus.evt_ready) begin
            m_vld = 0;
        end
        if (old_phase == 0 && bus.cfg_valid) m_lim[bus.cfg_chan] = int'(bus.cfg_limit);
        case (old_phase)
            0: if (bus.start) begin
                m_phase = 1; ncnt = '{0, 0}; m_ovf = '{0, 0};
            end
            1: if (bus.stop) m_phase = 2;
            default: if (!any_pend && free_s) m_phase = 0;
        endcase
        m_cnt = ncnt;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("count0",    int'(bus.count0),    m_cnt[0]);
        check_val("count1",    int'(bus.count1),    m_cnt[1]);
        check_val("evt_valid", int'(bus.evt_valid), int'(m_vld));
        check_val("evt_chan",  int'(bus.evt_chan),  m_chan);
        check_val("ovf",       int'(bus.ovf),       int'({m_ovf[1], m_ovf[0]}));
        check_val("busy",      int'(bus.busy),      int'(m_phase != 0));
        check_val("cfg_ready", int'(bus.cfg_ready), int'(m_phase == 0));
    endtask

    task automatic clear_inputs();
        bus.start = 0; bus.stop = 0; bus.cfg_valid = 0;
        bus.cfg_chan = 0; bus.cfg_limit = '0; bus.evt_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic write_limit(input int chan, input int lim);
        bus.cfg_valid = 1; bus.cfg_chan = chan[0]; bus.cfg_limit = lim[WIDTH-1:0];
        tick();
        bus.cfg_valid = 0;
    endtask

    task automatic pulse_start();
        bus.start = 1; tick(); bus.start = 0;
    endtask

    task automatic stop_and_drain();
        bus.stop = 1; tick(); bus.stop = 0;
        bus.evt_ready = 1;
        for (int i = 0; i < 20 && bus.busy; i++) tick();
        check_val("drain_to_idle", int'(bus.busy), 0);
    endtask

    int exp_v2[8] = '{0, 0, 0, 0, 1, 0, 1, 1};
    int exp_c2[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    int exp_v3[9] = '{0, 0, 0, 0, 1, 1, 0, 1, 1};
    int exp_c3[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 1};

    initial begin
        rst = 1;
        clear_inputs();
        m_phase = 0; m_cnt = '{0, 0}; m_lim = '{10, 10};
        m_pend = '{0, 0}; m_vld = 0; m_chan = 0; m_ovf = '{0, 0}; m_last = 1;

        // Reset values, then default-limit run: both wrap at S+11.
        do_reset();
        check_val("rst_count0",    int'(bus.count0), 0);
        check_val("rst_evt_valid", int'(bus.evt_valid), 0);
        check_val("rst_ovf",       int'(bus.ovf), 0);
        check_val("rst_busy",      int'(bus.busy), 0);
        check_val("rst_cfg_ready", int'(bus.cfg_ready), 1);
        bus.evt_ready = 1;
        pulse_start();
        for (int k = 1; k <= 13; k++) begin
            tick();
            check_val("def_count0", int'(bus.count0), k % 11);
            if (k == 12) begin
                check_val("def_first_vld",  int'(bus.evt_valid), 1);
                check_val("def_first_chan", int'(bus.evt_chan), 0);
            end
            if (k == 13) check_val("def_second_chan", int'(bus.evt_chan), 1);
        end
        stop_and_drain();

        // Limits 2 and 4.
        do_reset();
        write_limit(0, 2);
        write_limit(1, 4);
        bus.evt_ready = 1;
        pulse_start();
        for (int k = 1; k <= 7; k++) begin
            tick();
            check_val("l24_count0", int'(bus.count0), k % 3);
            check_val("l24_count1", int'(bus.count1), k % 5);
            check_val("l24_vld",    int'(bus.evt_valid), exp_v2[k]);
            if (exp_v2[k] == 1) check_val("l24_chan", int'(bus.evt_chan), exp_c2[k]);
        end
        stop_and_drain();

        // Simultaneous wraps alternate 0,1 then 0,1.
        do_reset();
        write_limit(0, 2);
        write_limit(1, 2);
        bus.evt_ready = 1;
        pulse_start();
        for (int k = 1; k <= 8; k++) begin
            tick();
            check_val("tie_vld", int'(bus.evt_valid), exp_v3[k]);
            if (exp_v3[k] == 1) check_val("tie_chan", int'(bus.evt_chan), exp_c3[k]);
        end
        stop_and_drain();

        // Limit 0 under backpressure: held event, then overflow.
        do_reset();
        write_limit(0, 0);
        write_limit(1, 15);
        pulse_start();
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k >= 2) begin
                check_val("hold_vld",  int'(bus.evt_valid), 1);
                check_val("hold_chan", int'(bus.evt_chan), 0);
            end
        end
        check_val("ovf_set", int'(bus.ovf), 1);
        bus.stop = 1; tick(); bus.stop = 0;
        tick();
        check_val("drain_busy",   int'(bus.busy), 1);
        check_val("drain_cfgrdy", int'(bus.cfg_ready), 0);
        check_val("drain_cnt1",   int'(bus.count1), 6);
        check_val("drain_ovf",    int'(bus.ovf), 1);
        bus.evt_ready = 1;
        for (int i = 0; i < 20 && bus.busy; i++) tick();
        check_val("ovf_idle_busy", int'(bus.busy), 0);
        check_val("ovf_sticky",    int'(bus.ovf), 1);
        pulse_start();
        check_val("ovf_cleared",   int'(bus.ovf), 0);
        stop_and_drain();

        // Reset mid-run with an event presented; config refused in RUN.
        do_reset();
        write_limit(0, 2);
        write_limit(1, 2);
        pulse_start();
        for (int k = 1; k <= 5; k++) tick();
        check_val("mid_vld", int'(bus.evt_valid), 1);
        bus.cfg_valid = 1; bus.cfg_chan = 0; bus.cfg_limit = 4'd1;
        check_val("run_cfg_ready", int'(bus.cfg_ready), 0);
        tick();
        bus.cfg_valid = 0;
        do_reset();
        check_val("mid_rst_vld",  int'(bus.evt_valid), 0);
        check_val("mid_rst_busy", int'(bus.busy), 0);
        bus.evt_ready = 1;
        pulse_start();
        for (int k = 1; k <= 12; k++) begin
            tick();
            check_val("mid_rst_count0", int'(bus.count0), k % 11);
        end
        stop_and_drain();

        // Random run control, config and backpressure.
        for (int i = 0; i < 4000; i++) begin
            rst           = ($urandom_range(0, 299) == 0);
            bus.start     = ($urandom_range(0, 14) == 0);
            bus.stop      = ($urandom_range(0, 39) == 0);
            bus.cfg_valid = ($urandom_range(0, 3) == 0);
            bus.cfg_chan  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       bus.cfg_limit = '0;
                1:       bus.cfg_limit = '1;
                default: bus.cfg_limit = 4'($urandom_range(0, 15));
            endcase
            bus.evt_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst = 0;
        clear_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/counter_scheduler.md
Name: counter_scheduler

Overview:
Run-control and event scheduler for a pair of free-running wrap counters that share one clock.
- Holds a programmable wrap limit per channel and sequences the counters through idle, run and drain phases.
- Arbitrates both channels' wrap events onto one valid/ready event port, round-robin.
- Sits between the host control logic and any consumer of counter wrap events.

Parameters:
WIDTH, 4, counter and limit width in bits
DEFAULT_LIMIT, 10, limit value loaded into both limit registers at reset

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle pulse; begin counting (honoured in IDLE only)
stop  input  1  single-cycle pulse; end counting (honoured in RUN only)
cfg_valid  input  1  limit write request
cfg_ready  output  1  limit write accepted; high only in IDLE
cfg_chan  input  1  target channel, 0 or 1
cfg_limit  input  WIDTH  new wrap limit
count0  output  WIDTH  channel 0 count
count1  output  WIDTH  channel 1 count
evt_valid  output  1  wrap event available
evt_ready  input  1  consumer accepts event
evt_chan  output  1  channel of the presented event
ovf  output  2  sticky per-channel lost-event flag
busy  output  1  state != IDLE

Behaviour:
- Reset values (synchronous, rst high at posedge):
  - state=IDLE; count0=count1=0; limit0=limit1=DEFAULT_LIMIT.
  - pend=2'b00; evt_valid=0; evt_chan=0; ovf=2'b00; last_grant=1, so channel 0 wins the first tie.
  - rst dominates every other input. Reset mid-run discards all pending and presented events.
- State machine, IDLE/RUN/DRAIN:
  - IDLE, start=1 -> RUN. At that edge count0 and count1 clear to 0 and ovf clears.
  - RUN, stop=1 -> DRAIN. Counts freeze at their current values.
  - DRAIN, pend==0 and evt_valid==0 (or the last event handshakes this edge) -> IDLE.
  - start is ignored outside IDLE. stop is ignored outside RUN. start and stop together in IDLE: start wins.
- Config:
  - cfg_ready = (state==IDLE), combinational from state.
  - When cfg_valid and cfg_ready are both high at an edge, limit[cfg_chan] <= cfg_limit.
  - Config together with start on the same edge: the new limit applies to that run.
- Counting, RUN only, each edge, per channel c:
  - If count_c == limit_c, count_c <= 0 and a wrap occurs; otherwise count_c <= count_c + 1.
  - Limit 0: count stays 0 and wraps every cycle. Limit 2^WIDTH-1: full-range counter.
  - Counts are visible directly as registers (no extra latency).
- Event path:
  - A wrap at edge E sets pend[c] after E.
  - The output slot (evt_valid, evt_chan) is free when evt_valid==0 or evt_valid&evt_ready at this edge.
  - When the slot is free and pend!=0, the slot loads at the next edge, so evt_valid is high after E+1 at the earliest.
  - Winner selection: the single pending channel, or, if both are pending, the channel != last_grant.
  - On load: last_grant <= winner and pend[winner] clears.
  - If pend[c] is loaded into the slot and channel c wraps on the same edge, pend[c] stays 1.
- Handshake:
  - evt_chan is stable while evt_valid=1 and evt_ready=0.
  - evt_valid deasserts after the accepting edge unless the slot reloads on that same edge, giving back-to-back events at 1 per cycle.
- Overflow: if channel c wraps at an edge where pend[c]==1 and pend[c] is not being moved to the slot, that event is lost and ovf[c] <= 1. ovf stays set until the next start or rst.
- DRAIN delivers every pending event before IDLE. Counts hold their frozen values in DRAIN and IDLE.

Test Plan:
- Reset, then read outputs -> count0=count1=0, evt_valid=0, ovf=0, busy=0, cfg_ready=1; start with no config -> both channels wrap after 11 cycles (limit 10).
- Config ch0=2, ch1=4, start at edge S, evt_ready=1 -> count0 sequence 0,1,2,0; ch0 wraps at S+3 and S+6, ch1 wraps at S+5; evt_valid pulses with evt_chan=0 after S+4, 1 after S+6, 0 after S+7.
- Both limits=2, evt_ready=1 -> simultaneous wraps at S+3; events appear as chan 0 after S+4, then chan 1 after S+5; next tie order is 0,1 again (alternation holds).
- Limit0=0, evt_ready=0 -> first event held with evt_chan=0 stable; pend0 refills; third wrap sets ovf=2'b01; ovf stays set through stop and clears on next start.
- Stop with both pend bits set and evt_ready=0 -> state DRAIN, busy=1, counts frozen, cfg_ready=0; raise evt_ready -> remaining events delivered, then IDLE.
- rst mid-RUN with evt_valid=1 -> next cycle all reset values, limits back to 10; cfg write attempted in RUN is not accepted (cfg_ready=0, limit unchanged).
